// File: rtl/nn_layer_sink.sv
// Result sink for an NN layer: buffers one frame of activations, then streams it out.
// Optional argmax tracking is enabled with macro NN_LAYER_SINK_ARGMAX_EN.
module nn_layer_sink #(
  parameter int NumEntries = 15,
  parameter int DataWidth  = 8,
  parameter int AddrWidth  = $clog2(NumEntries)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [AddrWidth-1:0] ram_addr_i,
  input  logic                 ram_we_i,
  input  logic [DataWidth-1:0] ram_din_i,
  output logic [DataWidth-1:0] ram_dout_o,
  input  logic                 req_i,
  output logic                 ack_o,
  output logic                 ready_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic [AddrWidth-1:0] m_index_o,
  output logic                 m_last_o
`ifdef NN_LAYER_SINK_ARGMAX_EN
  ,
  output logic [AddrWidth-1:0] argmax_o,
  output logic                 argmax_valid_o
`endif
);

  typedef enum logic [1:0] {StIdle, StAck, StDrain} state_t;

  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumEntries - 1);

  state_t                 r_state;
  state_t                 w_nextState;
  logic [DataWidth-1:0]   r_mem [NumEntries];
  logic [NumEntries-1:0]  r_written;
  logic [AddrWidth-1:0]   r_index;
  logic [DataWidth-1:0]   r_dout;

  logic                   w_addrInRange;
  logic                   w_wrEn;
  logic                   w_isLast;
  logic                   w_fire;
  logic                   w_lastFire;
  logic [DataWidth-1:0]   w_beatData;

  assign w_addrInRange = (ram_addr_i <= LastIdx);
  assign w_wrEn        = (r_state == StIdle) && ram_we_i && w_addrInRange;
  assign w_isLast      = (r_index == LastIdx);
  assign w_fire        = (r_state == StDrain) && m_ready_i;
  assign w_lastFire    = w_fire && w_isLast;
  // Entries never written this frame stream as zero regardless of stale RAM contents.
  assign w_beatData    = r_written[r_index] ? r_mem[r_index] : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      StIdle:  if (req_i)      w_nextState = StAck;
      StAck:   if (!req_i)     w_nextState = StDrain;
      StDrain: if (w_lastFire) w_nextState = StIdle;
      default:                 w_nextState = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_wrEn) begin
      r_mem[ram_addr_i] <= ram_din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_index   <= '0;
      r_written <= '0;
      r_dout    <= '0;
    end else begin
      if (w_wrEn) begin
        r_written[ram_addr_i] <= 1'b1;
      end
      if (w_fire) begin
        if (w_isLast) begin
          r_index   <= '0;
          r_written <= '0;
        end else begin
          r_index <= r_index + 1'b1;
        end
      end
      if (w_addrInRange && r_written[ram_addr_i]) begin
        r_dout <= r_mem[ram_addr_i];
      end else begin
        r_dout <= '0;
      end
    end
  end

  assign ram_dout_o = r_dout;
  assign ready_o    = reset_i && (r_state == StIdle);
  assign ack_o      = (r_state == StAck);
  assign m_valid_o  = (r_state == StDrain);
  assign m_data_o   = m_valid_o ? w_beatData : '0;
  assign m_index_o  = r_index;
  assign m_last_o   = m_valid_o && w_isLast;

`ifdef NN_LAYER_SINK_ARGMAX_EN
  logic [DataWidth-1:0] r_maxVal;
  logic [AddrWidth-1:0] r_maxIdx;
  logic [AddrWidth-1:0] r_argmax;
  logic                 r_argmaxValid;
  logic                 w_newMax;

  // Strict greater-than keeps the lowest index on ties; beat 0 always seeds the max.
  assign w_newMax = (r_index == '0) || ($signed(w_beatData) > $signed(r_maxVal));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_maxVal      <= '0;
      r_maxIdx      <= '0;
      r_argmax      <= '0;
      r_argmaxValid <= 1'b0;
    end else begin
      if ((r_state == StIdle) && req_i) begin
        r_argmaxValid <= 1'b0;
      end
      if (w_fire && w_newMax) begin
        r_maxVal <= w_beatData;
        r_maxIdx <= r_index;
      end
      if (w_lastFire) begin
        r_argmax      <= w_newMax ? r_index : r_maxIdx;
        r_argmaxValid <= 1'b1;
      end
    end
  end

  assign argmax_o       = r_argmax;
  assign argmax_valid_o = r_argmaxValid;
`endif

endmodule

// File: tb/tb_nn_layer_sink.sv
// Scoreboard bench for nn_layer_sink; argmax checks build only with NN_LAYER_SINK_ARGMAX_EN.
module tb_nn_layer_sink;

  localparam int NumEntries = 15;
  localparam int DataWidth  = 8;
  localparam int AddrWidth  = 4;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [AddrWidth-1:0] idx;
    logic                 last;
  } beat_t;

  logic                 clk;
  logic                 resetN;
  logic [AddrWidth-1:0] ramAddr;
  logic                 ramWe;
  logic [DataWidth-1:0] ramDin;
  logic [DataWidth-1:0] ramDout;
  logic                 req;
  logic                 ack;
  logic                 ready;
  logic                 mValid;
  logic                 mReady;
  logic [DataWidth-1:0] mData;
  logic [AddrWidth-1:0] mIndex;
  logic                 mLast;
`ifdef NN_LAYER_SINK_ARGMAX_EN
  logic [AddrWidth-1:0] argmax;
  logic                 argmaxValid;
  logic [AddrWidth-1:0] expArgmax;
`endif

  int vecCount  = 0;
  int missCount = 0;

  logic [DataWidth-1:0]  expMem [NumEntries];
  logic [NumEntries-1:0] expWritten;
  beat_t                 sbQ [$];
  logic [3:0]            readyPat;

  nn_layer_sink #(
    .NumEntries(NumEntries),
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth)
  ) dut (
    .clk_i     (clk),
    .reset_i   (resetN),
    .ram_addr_i(ramAddr),
    .ram_we_i  (ramWe),
    .ram_din_i (ramDin),
    .ram_dout_o(ramDout),
    .req_i     (req),
    .ack_o     (ack),
    .ready_o   (ready),
    .m_valid_o (mValid),
    .m_ready_i (mReady),
    .m_data_o  (mData),
    .m_index_o (mIndex),
    .m_last_o  (mLast)
`ifdef NN_LAYER_SINK_ARGMAX_EN
    ,
    .argmax_o      (argmax),
    .argmax_valid_o(argmaxValid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [AddrWidth-1:0] addr, input logic [DataWidth-1:0] data);
    ramWe   = 1'b1;
    ramAddr = addr;
    ramDin  = data;
    tick();
    ramWe = 1'b0;
    if (int'(addr) < NumEntries) begin
      expMem[addr]     = data;
      expWritten[addr] = 1'b1;
    end
  endtask

  task automatic checkRead(input logic [AddrWidth-1:0] addr);
    logic [DataWidth-1:0] exp;
    exp = '0;
    if (int'(addr) < NumEntries && expWritten[addr]) exp = expMem[addr];
    ramAddr = addr;
    tick();
    checkOutput("ramDout", ramDout, exp);
  endtask

  task automatic pushFrame();
    beat_t b;
    logic signed [DataWidth-1:0] best;
    best = '0;
    for (int i = 0; i < NumEntries; i++) begin
      b.data = expWritten[i] ? expMem[i] : '0;
      b.idx  = AddrWidth'(i);
      b.last = (i == NumEntries - 1);
      sbQ.push_back(b);
`ifdef NN_LAYER_SINK_ARGMAX_EN
      if (i == 0 || $signed(b.data) > best) begin
        best      = $signed(b.data);
        expArgmax = AddrWidth'(i);
      end
`endif
    end
    expWritten = '0;
  endtask

  task automatic runFrame(input bit stall, input bit reqWrite, input logic [AddrWidth-1:0] rwAddr,
                          input logic [DataWidth-1:0] rwData, input bit ackWrite, input int abortAt);
    int cycles;
    int beats;
    bit aborted;
    checkOutput("readyIdle", ready, 1);
    req = 1'b1;
    if (reqWrite) begin
      ramWe   = 1'b1;
      ramAddr = rwAddr;
      ramDin  = rwData;
      expMem[rwAddr]     = rwData;
      expWritten[rwAddr] = 1'b1;
    end
    tick();
    ramWe = 1'b0;
    checkOutput("ackHigh", ack, 1);
    checkOutput("readyAck", ready, 0);
`ifdef NN_LAYER_SINK_ARGMAX_EN
    checkOutput("argmaxCleared", argmaxValid, 0);
`endif
    pushFrame();
    if (ackWrite) begin
      ramWe   = 1'b1;
      ramAddr = 4'd4;
      ramDin  = 8'h55;
    end
    tick();
    ramWe = 1'b0;
    checkOutput("ackHold", ack, 1);
    req = 1'b0;
    tick();
    checkOutput("ackDrop", ack, 0);

    cycles  = 0;
    beats   = 0;
    aborted = 1'b0;
    while (sbQ.size() > 0 && cycles < 100) begin
      mReady = stall ? readyPat[cycles % 4] : 1'b1;
      req    = stall && cycles >= 2 && cycles < 5;
      checkOutput("mValid", mValid, 1);
      checkOutput("ackDrain", ack, 0);
      checkOutput("readyDrain", ready, 0);
      checkOutput("mData", mData, sbQ[0].data);
      checkOutput("mIndex", mIndex, sbQ[0].idx);
      checkOutput("mLast", mLast, sbQ[0].last);
      if (beats == abortAt) begin
        aborted = 1'b1;
        break;
      end
      if (mReady) begin
        void'(sbQ.pop_front());
        beats++;
      end
      tick();
      cycles++;
    end
    req    = 1'b0;
    mReady = 1'b1;

    if (aborted) begin
      resetN = 1'b0;
      tick();
      checkOutput("abortValid", mValid, 0);
      checkOutput("abortReady", ready, 0);
      checkOutput("abortAck", ack, 0);
      checkOutput("abortData", mData, 0);
      checkOutput("abortIndex", mIndex, 0);
      resetN = 1'b1;
      #1;
      checkOutput("abortReadyRel", ready, 1);
      sbQ.delete();
      expWritten = '0;
    end else begin
      checkOutput("drainPending", sbQ.size(), 0);
      checkOutput("validAfter", mValid, 0);
      checkOutput("readyAfter", ready, 1);
      if (!stall) checkOutput("drainCycles", cycles, NumEntries);
`ifdef NN_LAYER_SINK_ARGMAX_EN
      checkOutput("argmaxValid", argmaxValid, 1);
      checkOutput("argmax", argmax, expArgmax);
`endif
    end
  endtask

  initial begin
    resetN     = 1'b0;
    ramAddr    = '0;
    ramWe      = 1'b0;
    ramDin     = '0;
    req        = 1'b0;
    mReady     = 1'b1;
    readyPat   = 4'b1001;
    expWritten = '0;
    for (int i = 0; i < NumEntries; i++) expMem[i] = '0;

    tick();
    tick();
    checkOutput("rstReady", ready, 0);
    checkOutput("rstAck", ack, 0);
    checkOutput("rstValid", mValid, 0);
    checkOutput("rstLast", mLast, 0);
    checkOutput("rstData", mData, 0);
    checkOutput("rstIndex", mIndex, 0);
    checkOutput("rstDout", ramDout, 0);
`ifdef NN_LAYER_SINK_ARGMAX_EN
    checkOutput("rstArgmax", argmax, 0);
    checkOutput("rstArgmaxValid", argmaxValid, 0);
`endif
    resetN = 1'b1;
    #1;
    checkOutput("relReady", ready, 1);
    tick();

    for (int i = 0; i < NumEntries; i++) applyStimulus(AddrWidth'(i), DataWidth'(i + 1));
    checkRead(4'd3);
    checkRead(4'd15);
    runFrame(1'b0, 1'b0, '0, '0, 1'b0, -1);

    applyStimulus(4'd2, 8'h10);
    applyStimulus(4'd5, 8'h7F);
    applyStimulus(4'd15, 8'hAA);
    checkRead(4'd15);
    checkRead(4'd5);
    runFrame(1'b0, 1'b0, '0, '0, 1'b0, -1);
    runFrame(1'b0, 1'b0, '0, '0, 1'b0, -1);

    applyStimulus(4'd0, 8'h81);
    applyStimulus(4'd3, 8'h3C);
    applyStimulus(4'd14, 8'hEE);
    checkRead(4'd3);
    runFrame(1'b1, 1'b1, 4'd9, 8'h33, 1'b1, -1);

    for (int i = 0; i < NumEntries; i++) applyStimulus(AddrWidth'(i), 8'hA0 + DataWidth'(i));
    runFrame(1'b0, 1'b0, '0, '0, 1'b0, 7);
    tick();
    applyStimulus(4'd1, 8'h21);
    applyStimulus(4'd13, 8'hC4);
    runFrame(1'b0, 1'b0, '0, '0, 1'b0, -1);

`ifdef NN_LAYER_SINK_ARGMAX_EN
    applyStimulus(4'd0, 8'hFD);
    applyStimulus(4'd1, 8'h09);
    applyStimulus(4'd2, 8'h09);
    applyStimulus(4'd3, 8'h80);
    applyStimulus(4'd14, 8'h00);
    runFrame(1'b0, 1'b0, '0, '0, 1'b0, -1);
    checkOutput("argmaxSpec", argmax, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/nn_layer_sink.md
NN_LAYER_SINK -- requirements
Module: nn_layer_sink

Interface
REQ-001 SHALL have parameter NumEntries, default 15, number of neuron outputs buffered per frame.
REQ-002 SHALL have parameter DataWidth, default 8, width of one signed fixed-point activation.
REQ-003 SHALL have parameter AddrWidth, default $clog2(NumEntries), buffer address width.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port ram_addr_i, input, AddrWidth, layer-driven buffer address.
REQ-007 SHALL have port ram_we_i, input, 1, layer write enable.
REQ-008 SHALL have port ram_din_i, input, DataWidth, layer write data.
REQ-009 SHALL have port ram_dout_o, output, DataWidth, read data for ram_addr_i.
REQ-010 SHALL have port req_i, input, 1, layer frame-complete request.
REQ-011 SHALL have port ack_o, output, 1, acknowledge to layer.
REQ-012 SHALL have port ready_o, output, 1, sink accepting a new frame.
REQ-013 SHALL have ports m_valid_o (output, 1), m_ready_i (input, 1), m_data_o (output, DataWidth), m_index_o (output, AddrWidth) and m_last_o (output, 1): the result stream.
REQ-014 SHALL have ports argmax_o (output, AddrWidth) and argmax_valid_o (output, 1), present only per REQ-031.

Function
REQ-015 SHALL implement FSM IDLE -> ACK -> DRAIN -> IDLE.
REQ-016 IDLE: ready_o=1; ram_we_i=1 with ram_addr_i<NumEntries writes ram_din_i to buffer and sets the entry's written bit.
REQ-017 Writes with ram_addr_i>=NumEntries, or in any state other than IDLE, SHALL be ignored.
REQ-018 ram_dout_o SHALL be buffer[ram_addr_i] registered, 1-cycle latency, in every state; out-of-range address returns 0.
REQ-019 IDLE with req_i=1 SHALL go to ACK next cycle; a write in that same cycle SHALL be committed.
REQ-020 ACK: ack_o=1, ready_o=0; stay while req_i=1; on req_i=0 deassert ack_o next cycle and enter DRAIN (four-phase handshake).
REQ-021 DRAIN: index counter starts at 0; m_valid_o=1, m_index_o=index, m_data_o=buffer[index], or 0 if the written bit is clear.
REQ-022 m_valid_o, m_data_o, m_index_o and m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-023 m_last_o=1 iff index==NumEntries-1.
REQ-024 A beat transfers when m_valid_o and m_ready_i are both 1; index then increments, with no bubble between beats.
REQ-025 Transfer of the last beat SHALL clear all written bits and return to IDLE next cycle, with ready_o=1 and m_valid_o=0.
REQ-026 req_i asserted during DRAIN SHALL be ignored until IDLE.
REQ-027 Full-throughput drain SHALL take exactly NumEntries cycles.

Reset
REQ-028 On a clk_i edge with reset_i=0: state=IDLE, index=0, all written bits cleared, ack_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, m_index_o=0, ram_dout_o=0, argmax_o=0, argmax_valid_o=0.
REQ-029 ready_o SHALL be 0 while reset_i=0 and 1 the first cycle after release.
REQ-030 Reset mid-ACK or mid-DRAIN SHALL abort the frame without emitting further beats; buffer contents are don't-care, but entries read as 0 because the written bits are clear.

Configuration
REQ-031 With macro NN_LAYER_SINK_ARGMAX_EN defined: during DRAIN, track the signed maximum of the streamed values; ties keep the lowest index. On the last beat transfer, load argmax_o and set argmax_valid_o=1. Clear argmax_valid_o on the next req_i accepted in IDLE.
REQ-032 Without NN_LAYER_SINK_ARGMAX_EN: argmax_o and argmax_valid_o SHALL be absent, and no comparator logic SHALL exist.

Verification
REQ-033 Write addresses 0..14 with values 1..15, pulse req_i, m_ready_i=1 -> ack_o high until req_i drops; 15 beats with data 1..15, m_last_o only on index 14; ready_o=1 afterwards.
REQ-034 Write only addresses 2 (0x10) and 5 (0x7F), then run a frame -> stream carries 0 everywhere except index 2=0x10 and index 5=0x7F; the next frame with no writes streams all zeros.
REQ-035 Toggle m_ready_i 1,0,0,1 during DRAIN -> no beat lost or duplicated; outputs stable while stalled.
REQ-036 Write addr 15 (out of range) and write during ACK -> buffer unchanged; ram_dout_o for addr 15 is 0; ram_dout_o for addr 3 equals the written value one cycle after addressing.
REQ-037 Assert reset_i=0 at beat 7 of DRAIN -> m_valid_o=0 next cycle, ready_o=1 after release, and the next frame streams only the new writes.
REQ-038 With NN_LAYER_SINK_ARGMAX_EN: values {-3,9,9,-128,...,0} -> argmax_o=1, argmax_valid_o=1 after the last beat.
